// File: rtl/stream_source.sv
// stb/ack word source: emits COUNT words (arithmetic START + k*STEP, or an LFSR
// sequence when STREAM_SOURCE_LFSR_EN is defined) with GAP idle cycles between words.
module stream_source #(
   parameter logic [15:0] COUNT = 16'd16,
   parameter logic [15:0] START = 16'h0000,
   parameter logic [15:0] STEP  = 16'h0001,
   parameter logic [15:0] GAP   = 16'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [15:0] output_out,
   output logic        output_out_stb,
   input  logic        output_out_ack,
   output logic        busy,
   output logic        done,
   output logic [15:0] words_sent,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      WAIT    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      state;
   logic [15:0] gap_cnt;
   logic [15:0] next_word;

`ifdef STREAM_SOURCE_LFSR_EN
   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   localparam logic [15:0] FIRST = (START == 16'h0000) ? 16'h0001 : START;

   assign next_word = {output_out[14:0],
                       output_out[15] ^ output_out[13] ^ output_out[12] ^ output_out[10]};
`else
   localparam logic [15:0] FIRST = START;

   assign next_word = output_out + STEP;
`endif

   assign state_dbg = state;

   // Handshake: a word transfers on a rising edge where output_out_stb and
   // output_out_ack are both high; stb/data stay frozen until then, and ack is
   // only looked at in PRESENT, so a permanently high ack is legal.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         output_out     <= 16'h0000;
         output_out_stb <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         words_sent     <= 16'd0;
         gap_cnt        <= 16'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  words_sent <= 16'd0;
                  done       <= 1'b0;
                  output_out <= FIRST;
                  if (COUNT == 16'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state          <= PRESENT;
                     output_out_stb <= 1'b1;
                     busy           <= 1'b1;
                  end
               end
            end
            PRESENT: begin
               if (output_out_ack) begin
                  output_out_stb <= 1'b0;
                  words_sent     <= words_sent + 16'd1;
                  output_out     <= next_word;
                  if (words_sent + 16'd1 == COUNT) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state   <= WAIT;
                     gap_cnt <= GAP;
                  end
               end
            end
            WAIT: begin
               if (gap_cnt == 16'd0) begin
                  state          <= PRESENT;
                  output_out_stb <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - 16'd1;
               end
            end
            default: begin
               state          <= IDLE;
               output_out_stb <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_source.sv
// Bench for stream_source: four differently parameterised instances, a table-driven
// basic run, hand-written corner sequences, and a random phase checked by a word/gap model.
module tb_stream_source;

   localparam int NI = 4;
   localparam logic [15:0] COUNT_P [NI] = '{16'd4,     16'd3,     16'd0,     16'd5};
   localparam logic [15:0] START_P [NI] = '{16'h0000,  16'hFFFE,  16'h1234,  16'h8000};
   localparam logic [15:0] STEP_P  [NI] = '{16'h0001,  16'h0001,  16'h0007,  16'h0101};
   localparam logic [15:0] GAP_P   [NI] = '{16'd0,     16'd3,     16'd0,     16'd1};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NI-1:0] start = '0;
   logic [NI-1:0] ack = '0;
   logic [NI-1:0] stb, busy, done;
   logic [15:0]   dout [NI];
   logic [15:0]   ws [NI];
   logic [1:0]    sdbg [NI];

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      stream_source #(
         .COUNT (COUNT_P[g]),
         .START (START_P[g]),
         .STEP  (STEP_P[g]),
         .GAP   (GAP_P[g])
      ) u_dut (
         .clk            (clk),
         .rst            (rst),
         .start          (start[g]),
         .output_out     (dout[g]),
         .output_out_stb (stb[g]),
         .output_out_ack (ack[g]),
         .busy           (busy[g]),
         .done           (done[g]),
         .words_sent     (ws[g]),
         .state_dbg      (sdbg[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // k-th word of a run for instance g, straight from the sequence definition.
   function automatic logic [15:0] word_at(input int g, input int k);
      logic [15:0] w;
`ifdef STREAM_SOURCE_LFSR_EN
      w = (START_P[g] == 16'h0000) ? 16'h0001 : START_P[g];
      for (int i = 0; i < k; i++) w = {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
`else
      w = START_P[g] + 16'(k * int'(STEP_P[g]));
`endif
      return w;
   endfunction

   // Reference model: run in progress, words delivered, and position in the gap.
   logic          p_rst = 1'b1;
   logic [NI-1:0] p_start = '0;
   logic [NI-1:0] p_ack = '0;
   logic [NI-1:0] m_busy = '0;
   logic [NI-1:0] m_done = '0;
   int            m_sent [NI];
   int            m_since [NI];

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (p_rst) begin
            m_busy[g] = 1'b0;
            m_done[g] = 1'b0;
            m_sent[g] = 0;
            m_since[g] = 0;
         end else if (!m_busy[g] && p_start[g]) begin
            m_sent[g] = 0;
            m_since[g] = 0;
            m_done[g] = (COUNT_P[g] == 16'd0);
            m_busy[g] = (COUNT_P[g] != 16'd0);
         end else if (m_busy[g]) begin
            if (m_since[g] == 0) begin
               if (p_ack[g]) begin
                  m_sent[g]++;
                  if (m_sent[g] == int'(COUNT_P[g])) begin
                     m_busy[g] = 1'b0;
                     m_done[g] = 1'b1;
                  end else begin
                     m_since[g] = 1;
                  end
               end
            end else begin
               m_since[g]++;
               if (m_since[g] == int'(GAP_P[g]) + 2) m_since[g] = 0;
            end
         end
         chk($sformatf("mdl%0d_stb", g), stb[g], m_busy[g] && (m_since[g] == 0));
         if (m_busy[g] && (m_since[g] == 0))
            chk($sformatf("mdl%0d_data", g), dout[g], word_at(g, m_sent[g]));
         chk($sformatf("mdl%0d_busy", g), busy[g], m_busy[g]);
         chk($sformatf("mdl%0d_done", g), done[g], m_done[g]);
         chk($sformatf("mdl%0d_ws", g), ws[g], m_sent[g]);
      end
      p_rst = rst;
      p_start = start;
      p_ack = ack;
   end

   typedef struct {
      logic        start;
      logic        ack;
      logic        exp_stb;
      logic [15:0] exp_data;
      logic        exp_busy;
      logic        exp_done;
      logic [15:0] exp_ws;
   } vec_t;

   vec_t        tbl [9];
   logic [15:0] exp_q [$];
   logic [15:0] got_q [$];
   int          cyc_q [$];

   // Start a run on instance g with ack tied high and record every transfer.
   task automatic run_collect(input int g);
      got_q.delete();
      cyc_q.delete();
      start[g] = 1'b1;
      ack[g] = 1'b1;
      for (int i = 0; i < 80; i++) begin
         logic fin;
         @(negedge clk);
         if (stb[g]) begin
            got_q.push_back(dout[g]);
            cyc_q.push_back(i);
         end
         fin = (i > 0) && done[g];
         nxt();
         start[g] = 1'b0;
         if (fin) break;
      end
      start[g] = 1'b0;
   endtask

   task automatic check_words(input string name);
      chk({name, "_nwords"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         logic [15:0] w;
         w = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
         chk({name, "_word"}, w, exp_q.pop_front());
      end
   endtask

   initial begin
      int n;
      tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0000,     1'b0, 1'b0, 16'd0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, word_at(0,0), 1'b1, 1'b0, 16'd0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, word_at(0,1), 1'b1, 1'b0, 16'd1};
      tbl[3] = '{1'b0, 1'b1, 1'b1, word_at(0,1), 1'b1, 1'b0, 16'd1};
      tbl[4] = '{1'b0, 1'b1, 1'b0, word_at(0,2), 1'b1, 1'b0, 16'd2};
      tbl[5] = '{1'b0, 1'b1, 1'b1, word_at(0,2), 1'b1, 1'b0, 16'd2};
      tbl[6] = '{1'b0, 1'b1, 1'b0, word_at(0,3), 1'b1, 1'b0, 16'd3};
      tbl[7] = '{1'b0, 1'b1, 1'b1, word_at(0,3), 1'b1, 1'b0, 16'd3};
      tbl[8] = '{1'b0, 1'b1, 1'b0, word_at(0,4), 1'b0, 1'b1, 16'd4};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Basic run, one row per cycle.
      for (int i = 0; i < 9; i++) begin
         start[0] = tbl[i].start;
         ack[0] = tbl[i].ack;
         @(negedge clk);
         chk($sformatf("tbl%0d_stb", i), stb[0], tbl[i].exp_stb);
         chk($sformatf("tbl%0d_data", i), dout[0], tbl[i].exp_data);
         chk($sformatf("tbl%0d_busy", i), busy[0], tbl[i].exp_busy);
         chk($sformatf("tbl%0d_done", i), done[0], tbl[i].exp_done);
         chk($sformatf("tbl%0d_ws", i), ws[0], tbl[i].exp_ws);
         nxt();
      end
      start[0] = 1'b0;

      // Back-pressure: ack low for 5 cycles after stb rises.
      start[0] = 1'b1;
      ack[0] = 1'b0;
      nxt();
      start[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_stb%0d", i), stb[0], 1'b1);
         chk($sformatf("bp_data%0d", i), dout[0], word_at(0, 0));
         nxt();
      end
      ack[0] = 1'b1;
      @(negedge clk);
      chk("bp_hold_ws", ws[0], 16'd0);
      nxt();
      ack[0] = 1'b0;
      @(negedge clk);
      chk("bp_xfer_stb", stb[0], 1'b0);
      chk("bp_xfer_ws", ws[0], 16'd1);
      nxt();
      ack[0] = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         logic fin;
         @(negedge clk);
         if (stb[0]) n++;
         fin = done[0];
         nxt();
         if (fin) break;
      end
      chk("bp_remaining_xfers", n, 3);
      chk("bp_final_ws", ws[0], 16'd4);
      chk("bp_final_done", done[0], 1'b1);

      // Gap of 3 and 16-bit wrap on instance 1.
      run_collect(1);
      for (int i = 1; i < 3; i++)
         chk($sformatf("gap_spacing%0d", i), (cyc_q.size() > i) ? cyc_q[i] - cyc_q[i-1] : -1, 5);
`ifdef STREAM_SOURCE_LFSR_EN
      exp_q = '{16'hFFFE, 16'hFFFC, 16'hFFF8};
`else
      exp_q = '{16'hFFFE, 16'hFFFF, 16'h0000};
`endif
      check_words("wrap");
      chk("wrap_done", done[1], 1'b1);

      // Zero-length run.
      start[2] = 1'b1;
      @(negedge clk);
      chk("zero_done_before", done[2], 1'b0);
      nxt();
      start[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("zero_done%0d", i), done[2], 1'b1);
         chk($sformatf("zero_stb%0d", i), stb[2], 1'b0);
         nxt();
      end

      // Seed/second word on instance 3.
      run_collect(3);
`ifdef STREAM_SOURCE_LFSR_EN
      exp_q = '{16'h8000, 16'h0001};
`else
      exp_q = '{16'h8000, 16'h8101};
`endif
      chk("seed_nwords", got_q.size(), 5);
      for (int i = 0; i < 2; i++)
         chk($sformatf("seed_word%0d", i), (got_q.size() > i) ? got_q[i] : 16'hxxxx, exp_q[i]);
      exp_q.delete();

      // Reset after 2 of 4 words, restart, and a start pulse while busy.
      start[0] = 1'b1;
      ack[0] = 1'b1;
      nxt();
      start[0] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ws[0] == 16'd2) break;
         nxt();
      end
      chk("rstmid_reached2", ws[0], 16'd2);
      nxt();
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_stb", stb[0], 1'b0);
      chk("rstmid_busy", busy[0], 1'b0);
      chk("rstmid_ws", ws[0], 16'd0);
      chk("rstmid_done", done[0], 1'b0);
      nxt();
      ack[0] = 1'b0;
      start[0] = 1'b1;
      nxt();
      start[0] = 1'b0;
      @(negedge clk);
      chk("restart_stb", stb[0], 1'b1);
      chk("restart_data", dout[0], word_at(0, 0));
      nxt();
      ack[0] = 1'b1;
      nxt();
      start[0] = 1'b1;
      nxt();
      start[0] = 1'b0;
      got_q.delete();
      for (int i = 0; i < 40; i++) begin
         logic fin;
         @(negedge clk);
         if (stb[0]) got_q.push_back(dout[0]);
         fin = done[0];
         nxt();
         if (fin) break;
      end
      for (int k = 1; k < 4; k++) exp_q.push_back(word_at(0, k));
      check_words("busy_start");
      chk("busy_start_ws", ws[0], 16'd4);

      // Random phase against the model.
      for (int c = 0; c < 1500; c++) begin
         for (int g = 0; g < NI; g++) begin
            ack[g] = ($urandom_range(0, 3) != 0);
            start[g] = ($urandom_range(0, 19) == 0);
         end
         rst = ($urandom_range(0, 299) == 0);
         nxt();
      end
      rst = 1'b0;
      start = '0;
      nxt();
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
